// File: rtl/iob2axi_wr_seg_pkg.sv
// Shared AXI4 field widths and encodings, plus constants for the IOB-to-AXI write
// segmenter.
package iob2axi_wr_seg_pkg;

  localparam int unsigned AxiIdW    = 1;
  localparam int unsigned AxiLenW   = 8;
  localparam int unsigned AxiSizeW  = 3;
  localparam int unsigned AxiBurstW = 2;
  localparam int unsigned AxiLockW  = 1;
  localparam int unsigned AxiCacheW = 4;
  localparam int unsigned AxiProtW  = 3;
  localparam int unsigned AxiQosW   = 4;
  localparam int unsigned AxiRespW  = 2;

  localparam logic [AxiBurstW-1:0] AxiBurstIncr = 2'b01;

  localparam logic [AxiRespW-1:0] AxiRespOkay   = 2'b00;
  localparam logic [AxiRespW-1:0] AxiRespSlverr = 2'b10;

  // Normal non-cacheable modifiable, unprivileged non-secure data access.
  localparam logic [AxiCacheW-1:0] AxiCacheModifiable = 4'd2;
  localparam logic [AxiProtW-1:0]  AxiProtNonSecure   = 3'd2;

  // AXI bursts must not cross this boundary.
  localparam int unsigned AxiBoundaryBytes = 4096;

endpackage

// File: rtl/iob2axi_wr_seg_buf.sv
// Two-entry FIFO between the native read port and the AXI W channel.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (empties the buffer)
//   push_i / data_i   write one entry
//   pop_i / data_o    data_o is the head entry, pop_i drops it
//   full_o / empty_o  occupancy flags
// Pushing while full is only legal together with a pop.
module iob2axi_wr_seg_buf #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      // Simultaneous push and pop leaves the count unchanged.
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/iob2axi_wr_seg.sv
// Copies N beats from a native read port to AXI4 write bursts.
// Each burst is min(remaining, BURST_MAX, beats to the next 4 KB boundary) long.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   run_i, addr_i, length_i     start pulse, aligned byte address, beat count
//   ready_o, error_o            idle flag, sticky bad-response flag for last transfer
//   m_valid_o/m_addr_o/m_ready_i/m_rdata_i/m_rstrb_i   native read port
//   aw*, w*, b*                 AXI4 write address, data and response channels
module iob2axi_wr_seg
  import iob2axi_wr_seg_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned BURST_MAX = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  run_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [LEN_W-1:0]      length_i,
  output logic                  ready_o,
  output logic                  error_o,

  output logic                  m_valid_o,
  output logic [ADDR_W-1:0]     m_addr_o,
  input  logic                  m_ready_i,
  input  logic [DATA_W-1:0]     m_rdata_i,
  input  logic [DATA_W/8-1:0]   m_rstrb_i,

  output logic [AxiIdW-1:0]     awid_o,
  output logic [ADDR_W-1:0]     awaddr_o,
  output logic [AxiLenW-1:0]    awlen_o,
  output logic [AxiSizeW-1:0]   awsize_o,
  output logic [AxiBurstW-1:0]  awburst_o,
  output logic [AxiLockW-1:0]   awlock_o,
  output logic [AxiCacheW-1:0]  awcache_o,
  output logic [AxiProtW-1:0]   awprot_o,
  output logic [AxiQosW-1:0]    awqos_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,

  output logic [DATA_W-1:0]     wdata_o,
  output logic [DATA_W/8-1:0]   wstrb_o,
  output logic                  wlast_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,

  input  logic [AxiIdW-1:0]     bid_i,
  input  logic [AxiRespW-1:0]   bresp_i,
  input  logic                  bvalid_i,
  output logic                  bready_o
);

  localparam int unsigned SizeLog = $clog2(DATA_W / 8);
  localparam int unsigned StrbW   = DATA_W / 8;
  localparam int unsigned BufW    = DATA_W + StrbW + 1;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;      // base address of the current burst
  logic [LEN_W-1:0]     rem_q, rem_d;        // beats left, current burst included
  logic [AxiLenW-1:0]   awlen_q, awlen_d;
  logic [8:0]           req_cnt_q, req_cnt_d; // native requests issued in this burst
  logic                 error_q, error_d;

  logic [8:0]           blen;
  logic [LEN_W-1:0]     rem_after;
  logic [ADDR_W-1:0]    next_base;
  logic [8:0]           first_beats, next_beats;

  logic                 push, pop, buf_full, buf_empty, buf_last;
  logic [BufW-1:0]      buf_din, buf_dout;

  logic                 unused_bid;
  assign unused_bid = ^bid_i;

  function automatic logic [8:0] burst_beats(input logic [11:0] page_off,
                                             input logic [LEN_W-1:0] remaining);
    logic [12:0] to_bound;
    logic [31:0] beats;
    to_bound = (13'(AxiBoundaryBytes) - {1'b0, page_off}) >> SizeLog;
    beats    = 32'(remaining);
    if ({19'd0, to_bound} < beats) beats = {19'd0, to_bound};
    if (BURST_MAX < beats) beats = BURST_MAX;
    return beats[8:0];
  endfunction

  assign blen        = {1'b0, awlen_q} + 9'd1;
  assign rem_after   = rem_q - LEN_W'(blen);
  assign next_base   = addr_q + (ADDR_W'(blen) << SizeLog);
  assign first_beats = burst_beats(addr_i[11:0], length_i);
  assign next_beats  = burst_beats(next_base[11:0], rem_after);

  // W channel straight from the buffer head.
  assign wvalid_o = ~buf_empty;
  assign pop      = wvalid_o & wready_i;
  assign wdata_o  = buf_dout[BufW-1 -: DATA_W];
  assign wstrb_o  = buf_dout[StrbW:1];
  assign buf_last = buf_dout[0];
  assign wlast_o  = buf_last;

  // A full buffer still takes a beat when its head leaves this cycle, which keeps
  // the native side streaming at one beat per cycle; only the native request
  // sees wready, every AXI valid comes from state or buffer registers.
  assign m_valid_o = (state_q == StData) && (req_cnt_q < blen) && (!buf_full || pop);
  assign m_addr_o  = addr_q + (ADDR_W'(req_cnt_q) << SizeLog);
  assign push      = m_valid_o & m_ready_i;
  assign buf_din   = {m_rdata_i, m_rstrb_i, (req_cnt_q == blen - 9'd1)};

  assign ready_o   = (state_q == StIdle);
  assign error_o   = error_q;
  assign awvalid_o = (state_q == StAddr);
  assign bready_o  = (state_q == StResp);
  assign awaddr_o  = addr_q;
  assign awlen_o   = awlen_q;
  assign awid_o    = '0;
  assign awsize_o  = AxiSizeW'(SizeLog);
  assign awburst_o = AxiBurstIncr;
  assign awlock_o  = '0;
  assign awcache_o = AxiCacheModifiable;
  assign awprot_o  = AxiProtNonSecure;
  assign awqos_o   = '0;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    awlen_d   = awlen_q;
    req_cnt_d = req_cnt_q;
    error_d   = error_q;
    unique case (state_q)
      StIdle: begin
        if (run_i && (length_i != '0)) begin
          addr_d    = addr_i;
          rem_d     = length_i;
          awlen_d   = AxiLenW'(first_beats - 9'd1);
          req_cnt_d = '0;
          error_d   = 1'b0;
          state_d   = StAddr;
        end
      end
      StAddr: begin
        if (awready_i) state_d = StData;
      end
      StData: begin
        if (push) req_cnt_d = req_cnt_q + 9'd1;
        if (pop && buf_last) state_d = StResp;
      end
      StResp: begin
        if (bvalid_i) begin
          if (bresp_i != AxiRespOkay) error_d = 1'b1;
          if (rem_after != '0) begin
            addr_d    = next_base;
            rem_d     = rem_after;
            awlen_d   = AxiLenW'(next_beats - 9'd1);
            req_cnt_d = '0;
            state_d   = StAddr;
          end else begin
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      rem_q     <= '0;
      awlen_q   <= '0;
      req_cnt_q <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      awlen_q   <= awlen_d;
      req_cnt_q <= req_cnt_d;
      error_q   <= error_d;
    end
  end

  iob2axi_wr_seg_buf #(
    .Width (BufW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (buf_din),
    .pop_i   (pop),
    .data_o  (buf_dout),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

endmodule
